// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, field layout, load encodings.
// Optional sub-word load extension is enabled with `define MEM_LOAD_EXT_EN.
package mem_stage_pkg;

`ifdef MEM_LOAD_EXT_EN
  localparam int EXE_TO_MEM_WD = 74;
`else
  localparam int EXE_TO_MEM_WD = 71;
`endif
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 39;

  // Field offsets inside exe_to_mem_bus
  localparam int PC_LSB     = 0;
  localparam int ALU_LSB    = 32;
  localparam int RFM_BIT    = 64;
  localparam int WADDR_LSB  = 65;
  localparam int REGW_BIT   = 70;
`ifdef MEM_LOAD_EXT_EN
  localparam int LD_UNS_BIT  = 71;
  localparam int LD_SIZE_LSB = 72;

  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;
`endif

  typedef struct packed {
`ifdef MEM_LOAD_EXT_EN
    logic [1:0]  ld_size;
    logic        ld_unsigned;
`endif
    logic        regw;
    logic [4:0]  waddr;
    logic        res_from_mem;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } exe_bundle_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline handshake and bus bundle around the memory stage (EXE in, WB/ID out, RAM read data).
// Bus widths follow MEM_LOAD_EXT_EN through mem_stage_pkg.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                     mem_allowin;
  logic                     exe_to_mem_valid;
  logic [EXE_TO_MEM_WD-1:0] exe_to_mem_bus;
  logic                     wb_allowin;
  logic                     mem_to_wb_valid;
  logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus;
  logic [MEM_TO_ID_WD-1:0]  mem_to_id_bus;
  logic [31:0]              data_sram_rdata;

  // slave: the stage itself
  modport slave (
    input  exe_to_mem_valid, exe_to_mem_bus, wb_allowin, data_sram_rdata,
    output mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus
  );

  // master: surrounding pipeline / RAM
  modport master (
    output exe_to_mem_valid, exe_to_mem_bus, wb_allowin, data_sram_rdata,
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// mem_load_align: lane select and sign/zero extension of a RAM read word.
// Only built when MEM_LOAD_EXT_EN is defined.
`ifdef MEM_LOAD_EXT_EN
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  output logic [31:0] data
);
  logic [31:0] shifted;
  logic [15:0] half;

  assign shifted = rdata >> {addr, 3'b000};
  assign half    = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (ld_size)
      LD_B:    data = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
      LD_H:    data = {{16{~ld_unsigned & half[15]}}, half};
      default: data = rdata;
    endcase
  end
endmodule
`endif

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EXE bundle, picks load data or ALU result for WB/ID.
// Sub-word load extension (mem_load_align) is included when MEM_LOAD_EXT_EN is defined.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  bus
);
  exe_bundle_t pl;
  logic        mem_valid;
  logic        ready_go;
  logic        mem_allowin;
  logic        load;
  logic        first;
  logic        buf_vld;
  logic [31:0] rdata_buf;
  logic [31:0] mem_rdata;
  logic [31:0] ld_data;
  logic [31:0] final_result;

  assign ready_go    = 1'b1;
  assign mem_allowin = ~mem_valid | (bus.wb_allowin & ready_go);
  assign load        = mem_allowin & bus.exe_to_mem_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      first     <= 1'b0;
      buf_vld   <= 1'b0;
    end else begin
      if (mem_allowin) mem_valid <= bus.exe_to_mem_valid;
      if (load) begin
        first   <= 1'b1;
        buf_vld <= 1'b0;
      end else begin
        first <= 1'b0;
        // RAM data is only valid in the first MEM cycle; keep it if WB stalls us
        if (first & mem_valid & ~bus.wb_allowin) buf_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) pl <= exe_bundle_t'(bus.exe_to_mem_bus);
    if (!load & first & mem_valid & ~bus.wb_allowin) rdata_buf <= bus.data_sram_rdata;
  end

  assign mem_rdata = buf_vld ? rdata_buf : bus.data_sram_rdata;

`ifdef MEM_LOAD_EXT_EN
  mem_load_align u_align (
    .rdata       (mem_rdata),
    .addr        (pl.alu_result[1:0]),
    .ld_size     (pl.ld_size),
    .ld_unsigned (pl.ld_unsigned),
    .data        (ld_data)
  );
`else
  assign ld_data = mem_rdata;
`endif

  assign final_result = pl.res_from_mem ? ld_data : pl.alu_result;

  assign bus.mem_allowin     = mem_allowin;
  assign bus.mem_to_wb_valid = mem_valid & ready_go;
  assign bus.mem_to_wb_bus   = {pl.regw, pl.waddr, final_result, pl.pc};
  assign bus.mem_to_id_bus   = {mem_valid, pl.regw, pl.waddr, final_result};
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic vs a bundle-level model.
// Extension scenario runs only when MEM_LOAD_EXT_EN is defined.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_stage_if io();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (io)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EXE_TO_MEM_WD-1:0] mk(input logic regw, input logic [4:0] waddr,
      input logic rfm, input logic [31:0] alu, input logic [31:0] pc,
      input logic [1:0] ld_size, input logic ld_uns);
`ifdef MEM_LOAD_EXT_EN
    return {ld_size, ld_uns, regw, waddr, rfm, alu, pc};
`else
    logic [2:0] unused;
    unused = {ld_size, ld_uns};
    return {regw, waddr, rfm, alu, pc};
`endif
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    io.exe_to_mem_valid = 1'b1;
    io.exe_to_mem_bus   = mk(1'b1, 5'd3, 1'b0, $urandom, $urandom, 2'd2, 1'b0);
    io.wb_allowin       = 1'b0;
    io.data_sram_rdata  = $urandom;
    tick(); tick();
    n_cmp++; if (io.mem_allowin !== 1'b1) begin n_err++; $display("FAIL rst_allowin got %b want 1", io.mem_allowin); end
    n_cmp++; if (io.mem_to_wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_wb_valid got %b want 0", io.mem_to_wb_valid); end
    n_cmp++; if (io.mem_to_id_bus[38] !== 1'b0) begin n_err++; $display("FAIL rst_id_valid got %b want 0", io.mem_to_id_bus[38]); end
    resetn = 1'b1;
    io.exe_to_mem_valid = 1'b0;
    tick();
    n_cmp++; if (io.mem_to_wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_idle_valid got %b want 0", io.mem_to_wb_valid); end
  endtask

  task automatic test_load_no_stall();
    io.exe_to_mem_valid = 1'b1;
    io.exe_to_mem_bus   = mk(1'b1, 5'd5, 1'b1, 32'h100, 32'h8000_0010, 2'd2, 1'b0);
    io.wb_allowin       = 1'b1;
    tick();
    io.exe_to_mem_valid = 1'b0;
    io.data_sram_rdata  = 32'hDEADBEEF;
    #1;
    n_cmp++; if (io.mem_to_wb_valid !== 1'b1) begin n_err++; $display("FAIL ld_valid got %b want 1", io.mem_to_wb_valid); end
    n_cmp++; if (io.mem_to_wb_bus !== {1'b1, 5'd5, 32'hDEADBEEF, 32'h8000_0010})
      begin n_err++; $display("FAIL ld_wb_bus got %h want %h", io.mem_to_wb_bus, {1'b1, 5'd5, 32'hDEADBEEF, 32'h8000_0010}); end
    n_cmp++; if (io.mem_to_id_bus !== {1'b1, 1'b1, 5'd5, 32'hDEADBEEF})
      begin n_err++; $display("FAIL ld_id_bus got %h want %h", io.mem_to_id_bus, {1'b1, 1'b1, 5'd5, 32'hDEADBEEF}); end
    tick();
    n_cmp++; if (io.mem_to_wb_valid !== 1'b0) begin n_err++; $display("FAIL ld_one_cycle got %b want 0", io.mem_to_wb_valid); end
  endtask

  task automatic test_load_stall();
    io.exe_to_mem_valid = 1'b1;
    io.exe_to_mem_bus   = mk(1'b1, 5'd7, 1'b1, 32'h200, 32'h1000, 2'd2, 1'b0);
    io.wb_allowin       = 1'b1;
    tick();
    io.exe_to_mem_valid = 1'b0;
    io.wb_allowin       = 1'b0;
    for (int c = 0; c < 3; c++) begin
      io.data_sram_rdata = (c == 0) ? 32'h12345678 : 32'hFFFFFFFF;
      #1;
      n_cmp++; if (io.mem_to_wb_bus[63:32] !== 32'h12345678)
        begin n_err++; $display("FAIL stall_result c%0d got %h want 12345678", c, io.mem_to_wb_bus[63:32]); end
      n_cmp++; if (io.mem_allowin !== 1'b0) begin n_err++; $display("FAIL stall_allowin c%0d got %b want 0", c, io.mem_allowin); end
      tick();
    end
    io.wb_allowin = 1'b1;
    #1;
    n_cmp++; if (io.mem_to_wb_bus[63:32] !== 32'h12345678)
      begin n_err++; $display("FAIL stall_release got %h want 12345678", io.mem_to_wb_bus[63:32]); end
    n_cmp++; if (io.mem_allowin !== 1'b1) begin n_err++; $display("FAIL stall_release_allowin got %b want 1", io.mem_allowin); end
    tick();
    n_cmp++; if (io.mem_to_wb_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain got %b want 0", io.mem_to_wb_valid); end
  endtask

  task automatic test_back_to_back();
    io.wb_allowin       = 1'b1;
    io.data_sram_rdata  = 32'hA5A5A5A5;
    io.exe_to_mem_valid = 1'b1;
    io.exe_to_mem_bus   = mk(1'b1, 5'd1, 1'b0, 32'h1, 32'h40, 2'd2, 1'b0);
    tick();
    io.exe_to_mem_bus   = mk(1'b1, 5'd2, 1'b0, 32'h2, 32'h44, 2'd2, 1'b0);
    #1;
    n_cmp++; if ({io.mem_to_wb_valid, io.mem_to_wb_bus[63:32]} !== {1'b1, 32'h1})
      begin n_err++; $display("FAIL b2b_first got %b/%h want 1/00000001", io.mem_to_wb_valid, io.mem_to_wb_bus[63:32]); end
    n_cmp++; if (dut.buf_vld !== 1'b0) begin n_err++; $display("FAIL b2b_buf_vld0 got %b want 0", dut.buf_vld); end
    tick();
    io.exe_to_mem_valid = 1'b0;
    #1;
    n_cmp++; if ({io.mem_to_wb_valid, io.mem_to_wb_bus[63:32]} !== {1'b1, 32'h2})
      begin n_err++; $display("FAIL b2b_second got %b/%h want 1/00000002", io.mem_to_wb_valid, io.mem_to_wb_bus[63:32]); end
    n_cmp++; if (dut.buf_vld !== 1'b0) begin n_err++; $display("FAIL b2b_buf_vld1 got %b want 0", dut.buf_vld); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    io.exe_to_mem_valid = 1'b1;
    io.exe_to_mem_bus   = mk(1'b1, 5'd9, 1'b1, 32'h300, 32'h2000, 2'd2, 1'b0);
    io.wb_allowin       = 1'b1;
    tick();
    io.exe_to_mem_valid = 1'b0;
    io.wb_allowin       = 1'b0;
    io.data_sram_rdata  = 32'h0BADF00D;
    tick();
    resetn = 1'b0;
    tick();
    n_cmp++; if (io.mem_to_wb_valid !== 1'b0) begin n_err++; $display("FAIL rms_valid got %b want 0", io.mem_to_wb_valid); end
    n_cmp++; if (io.mem_allowin !== 1'b1) begin n_err++; $display("FAIL rms_allowin got %b want 1", io.mem_allowin); end
    n_cmp++; if (io.mem_to_id_bus[38] !== 1'b0) begin n_err++; $display("FAIL rms_id_valid got %b want 0", io.mem_to_id_bus[38]); end
    resetn = 1'b1;
    io.exe_to_mem_valid = 1'b1;
    io.exe_to_mem_bus   = mk(1'b1, 5'd10, 1'b1, 32'h304, 32'h2004, 2'd2, 1'b0);
    io.wb_allowin       = 1'b1;
    tick();
    io.exe_to_mem_valid = 1'b0;
    io.data_sram_rdata  = 32'hCAFEF00D;
    #1;
    n_cmp++; if (io.mem_to_wb_bus[63:32] !== 32'hCAFEF00D)
      begin n_err++; $display("FAIL rms_live got %h want cafef00d", io.mem_to_wb_bus[63:32]); end
    tick();
  endtask

  task automatic test_bubble();
    io.exe_to_mem_valid = 1'b0;
    io.wb_allowin       = 1'b1;
    for (int c = 0; c < 3; c++) begin
      io.exe_to_mem_bus = mk(1'b1, 5'd1, 1'b0, $urandom, $urandom, 2'd2, 1'b0);
      tick();
      n_cmp++; if (io.mem_to_wb_valid !== 1'b0) begin n_err++; $display("FAIL bubble_valid c%0d got %b want 0", c, io.mem_to_wb_valid); end
      n_cmp++; if (io.mem_to_id_bus[38] !== 1'b0) begin n_err++; $display("FAIL bubble_id c%0d got %b want 0", c, io.mem_to_id_bus[38]); end
    end
  endtask

`ifdef MEM_LOAD_EXT_EN
  task automatic test_load_ext();
    io.wb_allowin       = 1'b1;
    io.exe_to_mem_valid = 1'b1;
    io.exe_to_mem_bus   = mk(1'b1, 5'd4, 1'b1, 32'h103, 32'h50, 2'd0, 1'b0);
    tick();
    io.exe_to_mem_bus   = mk(1'b1, 5'd6, 1'b1, 32'h102, 32'h54, 2'd1, 1'b1);
    io.data_sram_rdata  = 32'h80F0_7F01;
    #1;
    n_cmp++; if (io.mem_to_wb_bus[63:32] !== 32'hFFFFFF80)
      begin n_err++; $display("FAIL ext_sbyte got %h want ffffff80", io.mem_to_wb_bus[63:32]); end
    tick();
    io.exe_to_mem_valid = 1'b0;
    io.wb_allowin       = 1'b0;
    #1;
    n_cmp++; if (io.mem_to_wb_bus[63:32] !== 32'h000080F0)
      begin n_err++; $display("FAIL ext_uhalf got %h want 000080f0", io.mem_to_wb_bus[63:32]); end
    tick();
    io.data_sram_rdata = 32'h0;
    io.wb_allowin      = 1'b1;
    #1;
    n_cmp++; if (io.mem_to_wb_bus[63:32] !== 32'h000080F0)
      begin n_err++; $display("FAIL ext_uhalf_held got %h want 000080f0", io.mem_to_wb_bus[63:32]); end
    tick();
  endtask
`endif

  // Model: an instruction's load value is whatever RAM returned in its first MEM cycle.
  task automatic test_random();
    logic        m_valid = 1'b0, m_first = 1'b0;
    logic        m_regw, m_rfm;
    logic [4:0]  m_waddr;
    logic [31:0] m_alu, m_pc, m_data, exp_res;
    logic        r_regw, r_rfm, exp_allow;
    logic [4:0]  r_waddr;
    logic [31:0] r_alu, r_pc;
    for (int c = 0; c < 400; c++) begin
      r_regw = 1'($urandom); r_waddr = 5'($urandom); r_rfm = 1'($urandom);
      r_alu = $urandom; r_pc = $urandom;
      io.exe_to_mem_valid = ($urandom_range(0, 9) < 7);
      io.exe_to_mem_bus   = mk(r_regw, r_waddr, r_rfm, r_alu, r_pc, 2'd2, 1'b0);
      io.wb_allowin       = ($urandom_range(0, 9) < 6);
      io.data_sram_rdata  = $urandom;
      #1;
      if (m_first) m_data = io.data_sram_rdata;
      exp_res   = m_rfm ? m_data : m_alu;
      exp_allow = !m_valid || io.wb_allowin;
      n_cmp++; if (io.mem_allowin !== exp_allow)
        begin n_err++; $display("FAIL rnd_allowin c%0d got %b want %b", c, io.mem_allowin, exp_allow); end
      n_cmp++; if (io.mem_to_wb_valid !== m_valid)
        begin n_err++; $display("FAIL rnd_valid c%0d got %b want %b", c, io.mem_to_wb_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (io.mem_to_wb_bus !== {m_regw, m_waddr, exp_res, m_pc})
          begin n_err++; $display("FAIL rnd_wb_bus c%0d got %h want %h", c, io.mem_to_wb_bus, {m_regw, m_waddr, exp_res, m_pc}); end
        n_cmp++; if (io.mem_to_id_bus !== {1'b1, m_regw, m_waddr, exp_res})
          begin n_err++; $display("FAIL rnd_id_bus c%0d got %h want %h", c, io.mem_to_id_bus, {1'b1, m_regw, m_waddr, exp_res}); end
      end else begin
        n_cmp++; if (io.mem_to_id_bus[38] !== 1'b0)
          begin n_err++; $display("FAIL rnd_id_bubble c%0d got %b want 0", c, io.mem_to_id_bus[38]); end
      end
      if (exp_allow && io.exe_to_mem_valid) begin
        m_valid = 1'b1; m_first = 1'b1;
        m_regw = r_regw; m_waddr = r_waddr; m_rfm = r_rfm; m_alu = r_alu; m_pc = r_pc;
      end else begin
        if (m_valid && io.wb_allowin) m_valid = 1'b0;
        m_first = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    resetn              = 1'b0;
    io.exe_to_mem_valid = 1'b0;
    io.exe_to_mem_bus   = '0;
    io.wb_allowin       = 1'b0;
    io.data_sram_rdata  = '0;
    test_reset();
    test_load_no_stall();
    test_load_stall();
    test_back_to_back();
    test_reset_mid_stall();
    test_bubble();
`ifdef MEM_LOAD_EXT_EN
    test_load_ext();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage; sits between the execute stage and the writeback stage.
- Latches the execute-stage bundle and collects the synchronous data-RAM read data.
- Selects the final result (load data or ALU result) and forwards it to writeback.
- Publishes its destination register and result to ID for RAW detection and forwarding.
- Holds RAM read data stable across writeback back-pressure.

Parameters:
- EXE_TO_MEM_WD, 71 (74 with MEM_LOAD_EXT_EN): input bundle width; defined in shared header.
- MEM_TO_WB_WD, 70: output bundle width.
- MEM_TO_ID_WD, 39: bypass bundle width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- mem_allowin  out  1  stage may accept a new instruction this cycle
- exe_to_mem_valid  in  1  upstream bundle valid
- exe_to_mem_bus  in  EXE_TO_MEM_WD  {regW, regWAddr[4:0], res_from_mem, alu_result[31:0], pc[31:0]}; with MEM_LOAD_EXT_EN, {ld_size[1:0], ld_unsigned} is prepended
- wb_allowin  in  1  downstream may accept
- mem_to_wb_valid  out  1  outgoing bundle valid
- mem_to_wb_bus  out  MEM_TO_WB_WD  {regW, regWAddr[4:0], final_result[31:0], pc[31:0]}
- mem_to_id_bus  out  MEM_TO_ID_WD  {mem_valid, regW, regWAddr[4:0], final_result[31:0]}
- data_sram_rdata  in  32  RAM read data; valid only in the cycle after the EXE-stage request

Behaviour:
- Reset (resetn=0 at posedge):
  - mem_valid=0, buf_vld=0.
  - Outputs after reset: mem_allowin=1, mem_to_wb_valid=0, mem_to_id_bus[38]=0.
  - Payload register contents are don't-care.
- Handshake:
  - ready_go=1.
  - mem_allowin = ~mem_valid | (wb_allowin & ready_go).
  - mem_to_wb_valid = mem_valid & ready_go.
  - On posedge with mem_allowin=1: mem_valid <= exe_to_mem_valid.
  - Payload register loads only when mem_allowin & exe_to_mem_valid.
- Latency: one cycle from EXE handoff to bundle visible at mem_to_wb_bus.
- Read-data hold buffer:
  - first flag: set on any payload load; cleared on the following posedge.
  - first=1: live data = data_sram_rdata. If mem_valid & ~wb_allowin, latch it into rdata_buf and set buf_vld=1.
  - Later cycles of a stalled instruction: use rdata_buf.
  - buf_vld clears on every payload load and on reset.
  - mem_rdata = buf_vld ? rdata_buf : data_sram_rdata.
- Result select: final_result = res_from_mem ? mem_rdata : alu_result. Without the option, this is the full 32-bit word.
- Bubble: mem_valid=0 means mem_to_id_bus valid bit=0, so ID must ignore the other fields; mem_to_wb_bus contents are don't-care.
- Simultaneous leave and enter (mem_valid=1, wb_allowin=1, exe_to_mem_valid=1): the new bundle replaces the old in one edge; first=1 and buf_vld=0 for the new bundle.
- Reset mid-stall discards the held instruction and rdata_buf.
- No writes to memory originate here; stores pass through with regW=0.

Optional Feature:
- Macro: MEM_LOAD_EXT_EN.
- Defined: input bus grows by 3 bits. Lane select uses alu_result[1:0].
  - ld_size=0: byte, lane = addr[1:0].
  - ld_size=1: halfword, lane = addr[1].
  - ld_size=2: word.
  - ld_size=3: treated as word.
  - Byte/halfword are zero-extended if ld_unsigned=1, otherwise sign-extended.
  - Extension is applied to mem_rdata (live or buffered) before result select.
- Undefined: widths as listed; word loads only.

Decomposition:
- Shared header: EXE_TO_MEM_WD, MEM_TO_WB_WD, MEM_TO_ID_WD; bus field offsets; ld_size encodings (LD_B=0, LD_H=1, LD_W=2), all conditional on MEM_LOAD_EXT_EN.
- One natural sub-module, mem_load_align: combinational lane select and extension, instantiated only under the macro.

Test Plan:
- Load, no stall: bundle res_from_mem=1, regW=1, regWAddr=5, alu=0x100; rdata=0xDEADBEEF in the next cycle → mem_to_wb_bus result=0xDEADBEEF, valid 1 cycle, mem_to_id_bus={1,1,5,0xDEADBEEF}.
- Load under stall: wb_allowin=0 for 3 cycles; rdata=0x12345678 in the first cycle, then 0xFFFFFFFF → result stays 0x12345678 throughout; mem_allowin=0 until wb_allowin=1.
- ALU op back-to-back: consecutive bundles alu=0x1, 0x2 with wb_allowin=1 → results 0x1 then 0x2 on consecutive cycles, no bubble; buf_vld stays 0.
- Reset mid-stall: resetn=0 while holding a load → next cycle mem_to_wb_valid=0, mem_allowin=1, mem_to_id_bus valid=0; a subsequent load uses live rdata.
- Bubble: exe_to_mem_valid=0 → mem_to_wb_valid=0, mem_to_id_bus[38]=0.
- MEM_LOAD_EXT_EN: rdata=0x80F0_7F01, addr[1:0]=3, signed byte → 0xFFFFFF80; addr=2, unsigned half → 0x000080F0.
